// File: rtl/jkff_bank_sequencer.sv
// Round-robin command sequencer for a bank of JK flip-flops.
// Drives one-clock j/k pulses per granted command and keeps a shadow copy of the bank state.
module jkff_bank_sequencer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req0,
    input  logic [1:0]       cmd0,
    input  logic [WIDTH-1:0] mask0,
    input  logic             req1,
    input  logic [1:0]       cmd1,
    input  logic [WIDTH-1:0] mask1,
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t           state, state_d;
    logic             last, last_d;
    logic             gnt0, gnt1;
    logic             ack0_d, ack1_d, busy_d;
    logic [WIDTH-1:0] j_d, k_d, q_d;

    // Next-state and next-output logic; j/k registers double as the latched command.
    always_comb begin
        state_d = state;
        last_d  = last;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        j_d     = '0;
        k_d     = '0;
        q_d     = q;
        // last==1 means requester 1 won most recently, so requester 0 wins a tie
        gnt0    = req0 & (~req1 | last);
        gnt1    = req1 & ~gnt0;

        case (state)
            IDLE: begin
                if (gnt0) begin
                    state_d = DRIVE;
                    last_d  = 1'b0;
                    ack0_d  = 1'b1;
                    j_d     = {WIDTH{cmd0[1]}} & mask0;
                    k_d     = {WIDTH{cmd0[0]}} & mask0;
                end else if (gnt1) begin
                    state_d = DRIVE;
                    last_d  = 1'b1;
                    ack1_d  = 1'b1;
                    j_d     = {WIDTH{cmd1[1]}} & mask1;
                    k_d     = {WIDTH{cmd1[0]}} & mask1;
                end
            end
            DRIVE: begin
                state_d = RECOVER;
                q_d     = (j & ~q) | (~k & q);
            end
            RECOVER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
            last  <= 1'b1;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            busy  <= 1'b0;
            j     <= '0;
            k     <= '0;
            q     <= '0;
        end else begin
            state <= state_d;
            last  <= last_d;
            ack0  <= ack0_d;
            ack1  <= ack1_d;
            busy  <= busy_d;
            j     <= j_d;
            k     <= k_d;
            q     <= q_d;
        end
    end

endmodule

// File: tb/tb_jkff_bank_sequencer.sv
// Bench for jkff_bank_sequencer: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_jkff_bank_sequencer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [1:0]   cmd0 = 2'b00, cmd1 = 2'b00;
    logic [W-1:0] mask0 = '0, mask1 = '0;
    logic         ack0, ack1, busy;
    logic [W-1:0] j, k, q;

    int vectors = 0;
    int errors  = 0;

    jkff_bank_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .clr(clr),
        .req0(req0), .cmd0(cmd0), .mask0(mask0),
        .req1(req1), .cmd1(cmd1), .mask1(mask1),
        .ack0(ack0), .ack1(ack1), .busy(busy),
        .j(j), .k(k), .q(q)
    );

    always #5 clk = ~clk;

    // Model: a command occupies a 3-cycle slot (waiting, driving, recovering).
    int           m_phase = 0;
    int           m_last  = 1;
    int           m_win   = 0;
    logic [1:0]   m_cmd   = 2'b00;
    logic [W-1:0] m_mask  = '0;
    logic [W-1:0] m_q     = '0;

    function automatic int pick(input logic r0, input logic r1, input int last);
        if (r0 && r1) return 1 - last;
        return r0 ? 0 : 1;
    endfunction

    function automatic logic [W-1:0] apply(input logic [W-1:0] qv, input logic [1:0] c,
                                           input logic [W-1:0] m);
        case (c)
            2'b01:   return qv & ~m;
            2'b10:   return qv | m;
            2'b11:   return qv ^ m;
            default: return qv;
        endcase
    endfunction

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            m_phase <= 0;
            m_last  <= 1;
            m_win   <= 0;
            m_q     <= '0;
        end else begin
            case (m_phase)
                0: if (req0 || req1) begin
                    m_win   <= pick(req0, req1, m_last);
                    m_last  <= pick(req0, req1, m_last);
                    m_cmd   <= (pick(req0, req1, m_last) == 0) ? cmd0 : cmd1;
                    m_mask  <= (pick(req0, req1, m_last) == 0) ? mask0 : mask1;
                    m_phase <= 1;
                end
                1: begin
                    m_q     <= apply(m_q, m_cmd, m_mask);
                    m_phase <= 2;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        logic         e_ack0, e_ack1, e_busy;
        logic [W-1:0] e_j, e_k;
        e_busy = (m_phase != 0);
        e_ack0 = (m_phase == 1) && (m_win == 0);
        e_ack1 = (m_phase == 1) && (m_win == 1);
        e_j    = (m_phase == 1 && m_cmd[1]) ? m_mask : '0;
        e_k    = (m_phase == 1 && m_cmd[0]) ? m_mask : '0;
        vectors++;
        if ({ack0, ack1, busy, j, k, q} !== {e_ack0, e_ack1, e_busy, e_j, e_k, m_q}) begin
            errors++;
            $display("FAIL cycle_check t=%0t got ack0=%b ack1=%b busy=%b j=%b k=%b q=%b want ack0=%b ack1=%b busy=%b j=%b k=%b q=%b",
                     $time, ack0, ack1, busy, j, k, q, e_ack0, e_ack1, e_busy, e_j, e_k, m_q);
        end
        vectors++;
        if (ack0 && ack1) begin
            errors++;
            $display("FAIL ack_overlap t=%0t got ack0=%b ack1=%b want not both", $time, ack0, ack1);
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, got, exp);
        end
    endtask

    // Post one command and return once the shadow update is visible.
    task automatic do_cmd(input int r, input logic [1:0] c, input logic [W-1:0] m,
                          output logic [W-1:0] oj, output logic [W-1:0] ok);
        bit seen = 1'b0;
        if (r == 0) begin req0 = 1'b1; cmd0 = c; mask0 = m; end
        else        begin req1 = 1'b1; cmd1 = c; mask1 = m; end
        for (int n = 0; n < 10 && !seen; n++) begin
            @(posedge clk); #2;
            if ((r == 0) ? ack0 : ack1) seen = 1'b1;
        end
        oj = j;
        ok = k;
        if (!seen) begin
            vectors++;
            errors++;
            $display("FAIL ack_timeout requester=%0d got no ack want ack within 10 clocks", r);
        end
        if (r == 0) begin req0 = 1'b0; cmd0 = 2'($urandom); mask0 = W'($urandom); end
        else        begin req1 = 1'b0; cmd1 = 2'($urandom); mask1 = W'($urandom); end
        @(posedge clk); #2;
    endtask

    initial begin
        logic [W-1:0] oj, ok;
        int who[$];
        int at[$];

        // Reset held with random inputs.
        repeat (3) begin
            @(posedge clk); #2;
            req0 = 1'($urandom); req1 = 1'($urandom);
            cmd0 = 2'($urandom); cmd1 = 2'($urandom);
            mask0 = W'($urandom); mask1 = W'($urandom);
        end
        check("reset_q", 16'(q), 16'h0);
        check("reset_jk", 16'({j, k}), 16'h0);
        check("reset_ctl", 16'({ack0, ack1, busy}), 16'h0);
        req0 = 1'b0; req1 = 1'b0;
        clr = 1'b1;
        repeat (3) begin @(posedge clk); #2; end
        check("idle_after_release", 16'({ack0, ack1, busy, j, k, q}), 16'h0);

        // Set then clear.
        do_cmd(0, 2'b10, 4'b0101, oj, ok);
        check("set_j", 16'(oj), 16'h5);
        check("set_k", 16'(ok), 16'h0);
        check("set_q", 16'(q), 16'h5);
        check("set_model_q", 16'(m_q), 16'h5);
        do_cmd(1, 2'b01, 4'b0001, oj, ok);
        check("clear_q", 16'(q), 16'h4);

        // Toggle three times, then hold.
        do_cmd(0, 2'b11, 4'b1111, oj, ok);
        check("toggle1_q", 16'(q), 16'hB);
        check("toggle1_model_q", 16'(m_q), 16'hB);
        do_cmd(0, 2'b11, 4'b1111, oj, ok);
        check("toggle2_q", 16'(q), 16'h4);
        do_cmd(0, 2'b11, 4'b1111, oj, ok);
        check("toggle3_q", 16'(q), 16'hB);
        do_cmd(1, 2'b00, 4'b1111, oj, ok);
        check("hold_jk", 16'({oj, ok}), 16'h0);
        check("hold_q", 16'(q), 16'hB);

        // Both requesters held high: alternate 0,1,0,1 three clocks apart.
        req0 = 1'b1; req1 = 1'b1;
        cmd0 = 2'b00; cmd1 = 2'b00;
        mask0 = W'($urandom); mask1 = W'($urandom);
        for (int c = 0; c < 13; c++) begin
            @(posedge clk); #2;
            if (ack0) begin who.push_back(0); at.push_back(c); end
            if (ack1) begin who.push_back(1); at.push_back(c); end
        end
        req0 = 1'b0; req1 = 1'b0;
        check("arb_count_ge4", 16'(who.size() >= 4), 16'h1);
        for (int i = 0; i < 4 && i < who.size(); i++) begin
            check($sformatf("arb_order%0d", i), 16'(who[i]), 16'(i % 2));
            if (i > 0) check($sformatf("arb_spacing%0d", i), 16'(at[i] - at[i-1]), 16'd3);
        end
        repeat (3) begin @(posedge clk); #2; end
        check("arb_q_held", 16'(q), 16'hB);

        // Reset during DRIVE loses the command; re-request applies it.
        req0 = 1'b1; cmd0 = 2'b10; mask0 = 4'b1111;
        for (int n = 0; n < 10 && !ack0; n++) begin @(posedge clk); #2; end
        check("mid_drive_ack_seen", 16'(ack0), 16'h1);
        clr = 1'b0;
        #1;
        check("mid_reset_q", 16'(q), 16'h0);
        check("mid_reset_j", 16'(j), 16'h0);
        check("mid_reset_ack", 16'({ack0, ack1}), 16'h0);
        req0 = 1'b0;
        @(posedge clk); #2;
        clr = 1'b1;
        do_cmd(0, 2'b10, 4'b1111, oj, ok);
        check("rerequest_q", 16'(q), 16'hF);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            if (!clr) begin
                clr = 1'b1;
            end else if ($urandom_range(0, 99) == 0) begin
                clr = 1'b0;
            end
            if (req0 && ack0) begin
                req0 = 1'b0; cmd0 = 2'($urandom); mask0 = W'($urandom);
            end else if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1'b1; cmd0 = 2'($urandom); mask0 = W'($urandom);
            end
            if (req1 && ack1) begin
                req1 = 1'b0; cmd1 = 2'($urandom); mask1 = W'($urandom);
            end else if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1'b1; cmd1 = 2'($urandom); mask1 = W'($urandom);
            end
        end

        @(posedge clk); #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
